mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single-port data memory between the MIPS CPU (port 0) and a second bus master such as a program loader or DMA engine (port 1). It accepts single-beat read/write requests, grants at most one per cycle, and drives the memory. It returns read data with one-cycle latency to the requester that issued the read. Arbitration is sticky round-robin with a burst limit, so neither master can starve the other.

## Interface
- AW, 8, address width
- DW, 8, data width
- MAX_BURST, 4, maximum consecutive grants to one port while the other port is requesting (≥1)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-low
- req0 / req1  in  1  request from port 0 (CPU) / port 1
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  AW  request address
- wdata0 / wdata1  in  DW  write data
- gnt0 / gnt1  out  1  grant; the transfer occurs in the cycle where req & gnt are both high
- rvalid0 / rvalid1  out  1  read data valid for that port
- rdata0 / rdata1  out  DW  read data, meaningful only while rvalid is high
- mem_en  out  1  memory access this cycle
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid in the cycle after a read with mem_en=1

## Operation
- **Requester contract:** hold req, we, addr and wdata stable until gnt is seen high. Dropping req before grant is allowed; that request is simply withdrawn.
- **Grant decision:** combinational from req0, req1 and the registered state (owner, cnt).
  - Only one port requesting → grant it.
  - Both requesting, cnt < MAX_BURST → grant owner.
  - Both requesting, cnt == MAX_BURST → grant the other port.
  - Neither requesting → no grant.
- **State update:**
  - Grant to owner → cnt = min(cnt+1, MAX_BURST).
  - Grant to the other port → owner = that port, cnt = 1.
  - No grant → owner unchanged, cnt = 0.
- **Memory side:** mem_en = gnt0|gnt1. mem_we/addr/wdata are muxed from the granted port. With no grant, mem_we=0 and mem_addr/mem_wdata=0.
- **Read return:**
  - A registered tag records {valid, port} for a granted read.
  - Next cycle, rvalidN=1 for the tagged port and rdataN = mem_rdata.
  - The non-tagged port has rvalid=0 and rdata=0.
  - Writes produce no rvalid.
- **Simultaneous events:** a new grant in the same cycle as a read return is legal. The return belongs to the previous cycle's tag.
- **While rst=0:**
  - gnt0 = gnt1 = 0 and mem_en = 0.
  - State is forced to owner=0, cnt=0, tag invalid.

## Timing
- **Reset values:** gnt0/1=0, rvalid0/1=0, rdata0/1=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, owner=0, cnt=0.
- **Grant latency:** 0 cycles (same cycle as req when selected).
- **Read latency:** rvalid is asserted exactly 1 cycle after the granting cycle.
- **Throughput:** 1 transfer per cycle total.
- **Reset mid-operation:** a read granted in cycle t, with rst low at the t→t+1 edge, gives no rvalid in t+1.
- **Worst-case wait:** a continuously requesting port waits at most MAX_BURST cycles.

## Structure
- Shared package mips_mem_pkg holds:
  - the default AW/DW constants;
  - port index constants PORT_CPU=0, PORT_AUX=1;
  - the tag typedef {valid, port}.
- One sub-module is natural: arb_sel, purely combinational. Inputs are req0, req1, owner, cnt. Outputs are the grant vector and next owner/cnt.
- mem_arbiter holds the registers, the memory mux and the read-return routing.

## Test plan
- **Reset, then CPU write:** hold rst=0 for 2 cycles → all outputs 0. Release, then req0=1, we0=1, addr0=5, wdata0=7 → same cycle gnt0=1, mem_en=1, mem_we=1, mem_addr=5, mem_wdata=7.
- **Port 1 read:** memory model has mem[8]=0x3C; req1 read addr 8 → gnt1=1 in cycle t. In t+1: rvalid1=1, rdata1=0x3C, rvalid0=0.
- **Burst limit:** req0 and req1 both held high from reset with MAX_BURST=4 → grant sequence 0,0,0,0,1,1,1,1,0,0,… with no idle cycles.
- **Interleaved reads:** port 0 reads addr 1 (mem=0x11) at t; port 1 reads addr 2 (mem=0x22) at t+1 → rvalid0/rdata0=0x11 at t+1, rvalid1/rdata1=0x22 at t+2, never both high.
- **Idle resets cnt:** port 0 gets 3 grants, then one cycle with no req, then both request → port 0 granted 4 more times before the first gnt1.
- **Reset mid-read:** port 0 read granted at t, rst=0 sampled at the next edge → rvalid0=0 in t+1; after release, owner=0 and cnt=0, checked by rerunning the burst sequence.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared widths, port indices and read-return tag type for the data-memory arbiter
package mips_mem_pkg;
  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;
  typedef struct packed {
    logic valid;
    logic port;
  } tag_t;
endpackage

// File: rtl/arb_sel.sv
// arb_sel: sticky round-robin grant selection with a burst limit (purely combinational)
//   i_req0/i_req1 : requests from port 0 / port 1
//   i_owner/i_cnt : registered owner port and its consecutive-grant count
//   o_gnt         : one-hot grant vector {port1, port0}
//   o_owner_nxt/o_cnt_nxt : state to register at the next edge
module arb_sel #(
  parameter int MAX_BURST = 4,
  parameter int CW = $clog2(MAX_BURST + 1)
) (
  input  logic          i_req0,
  input  logic          i_req1,
  input  logic          i_owner,
  input  logic [CW-1:0] i_cnt,
  output logic [1:0]    o_gnt,
  output logic          o_owner_nxt,
  output logic [CW-1:0] o_cnt_nxt
);
  localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);
  logic w_any;
  logic w_sel;
  always_comb begin
    w_any = i_req0 | i_req1;
    // under contention the owner keeps the memory until it has used up its burst
    w_sel = (i_req0 & i_req1) ? ((i_cnt < MAXC) ? i_owner : ~i_owner) : i_req1;
    o_gnt = w_any ? (w_sel ? 2'b10 : 2'b01) : 2'b00;
    o_owner_nxt = w_any ? w_sel : i_owner;
    o_cnt_nxt = !w_any ? '0 : (w_sel != i_owner) ? CW'(1) : (i_cnt == MAXC) ? MAXC : i_cnt + CW'(1);
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port data memory between the CPU (port 0) and an auxiliary master (port 1)
//   clk, rst (sync, active-low)
//   reqN/weN/addrN/wdataN : single-beat request from port N; gntN marks the transfer cycle
//   rvalidN/rdataN        : read return to port N, one cycle after its grant
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : memory side
module mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  localparam int CW = $clog2(MAX_BURST + 1);
  logic          r_owner;
  logic [CW-1:0] r_cnt;
  tag_t          r_tag;
  logic [1:0]    w_gnt;
  logic          w_owner_nxt;
  logic [CW-1:0] w_cnt_nxt;
  arb_sel #(.MAX_BURST(MAX_BURST), .CW(CW)) u_sel (
    .i_req0     (req0),
    .i_req1     (req1),
    .i_owner    (r_owner),
    .i_cnt      (r_cnt),
    .o_gnt      (w_gnt),
    .o_owner_nxt(w_owner_nxt),
    .o_cnt_nxt  (w_cnt_nxt)
  );
  always_comb begin
    // grants are suppressed while reset is held so the memory sees no access
    gnt0 = rst & w_gnt[0];
    gnt1 = rst & w_gnt[1];
    mem_en = gnt0 | gnt1;
    mem_we = gnt1 ? we1 : (gnt0 & we0);
    mem_addr = gnt1 ? addr1 : gnt0 ? addr0 : '0;
    mem_wdata = gnt1 ? wdata1 : gnt0 ? wdata0 : '0;
    rvalid0 = r_tag.valid & (r_tag.port == PORT_CPU);
    rvalid1 = r_tag.valid & (r_tag.port == PORT_AUX);
    rdata0 = rvalid0 ? mem_rdata : '0;
    rdata1 = rvalid1 ? mem_rdata : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_owner <= PORT_CPU;
      r_cnt <= '0;
      r_tag <= '0;
    end else begin
      r_owner <= w_owner_nxt;
      r_cnt <= w_cnt_nxt;
      r_tag <= '{valid: mem_en & ~mem_we, port: gnt1};
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter with a read-return scoreboard
module tb_mem_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [7:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic       gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we;
  logic [7:0] rdata0, rdata1, mem_addr, mem_wdata;
  logic [7:0] mem_rdata = '0;
  logic [7:0] mem [256];
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic       port;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  mem_arbiter #(.AW(8), .DW(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst) begin
      mem[1] <= 8'h11;
      mem[2] <= 8'h22;
      mem[8] <= 8'h3C;
    end else if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
  end

  task automatic test_reset;
    @(negedge clk);
    #1;
    checks++;
    if ({gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, rdata0, rdata1, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b%b rvalid=%b%b en=%b we=%b rdata=%h/%h addr=%h wdata=%h, required all 0",
               gnt1, gnt0, rvalid1, rvalid0, mem_en, mem_we, rdata1, rdata0, mem_addr, mem_wdata);
    end
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1;
    #1;
    checks++;
    if ({gnt0, gnt1, mem_en} !== 3'b000) begin
      errors++;
      $display("FAIL reset_blocks_grant: gnt0=%b gnt1=%b mem_en=%b, required 0 0 0", gnt0, gnt1, mem_en);
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_cpu_write;
    @(negedge clk);
    rst = 1'b1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'd5; wdata0 = 8'd7;
    #1;
    checks++;
    if ({gnt0, gnt1, mem_en, mem_we, mem_addr, mem_wdata} !== {4'b1011, 8'd5, 8'd7}) begin
      errors++;
      $display("FAIL cpu_write: gnt0=%b gnt1=%b en=%b we=%b addr=%0d wdata=%0d, required 1 0 1 1 5 7",
               gnt0, gnt1, mem_en, mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk);
    req0 = 1'b0; we0 = 1'b0;
    #1;
    checks++;
    if ({rvalid0, rvalid1, mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL write_no_rvalid: rvalid=%b%b en=%b we=%b addr=%h wdata=%h, required all 0",
               rvalid1, rvalid0, mem_en, mem_we, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_port1_read;
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'd8;
    #1;
    checks++;
    if ({gnt0, gnt1, mem_en, mem_we, mem_addr} !== {4'b0110, 8'd8}) begin
      errors++;
      $display("FAIL port1_read_grant: gnt0=%b gnt1=%b en=%b we=%b addr=%0d, required 0 1 1 0 8",
               gnt0, gnt1, mem_en, mem_we, mem_addr);
    end
    exp_q.push_back('{1'b1, 8'h3C});
    @(negedge clk);
    req1 = 1'b0;
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL port1_read_sb: scoreboard empty, required one entry");
    end else begin
      e = exp_q.pop_front();
      if ({rvalid1, rdata1, rvalid0, rdata0} !== {1'b1, e.data, 1'b0, 8'h00}) begin
        errors++;
        $display("FAIL port1_read_return: rvalid1=%b rdata1=%h rvalid0=%b rdata0=%h, required 1 %h 0 00",
                 rvalid1, rdata1, rvalid0, rdata0, e.data);
      end
    end
  endtask

  task automatic test_burst(input bit do_reset);
    bit exp1;
    if (do_reset) begin
      @(negedge clk);
      rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    we0 = 1'b1; we1 = 1'b1; addr0 = 8'd40; addr1 = 8'd41; wdata0 = 8'hA0; wdata1 = 8'hA1;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      exp1 = ((i / 4) % 2) != 0;
      checks++;
      if ({gnt1, gnt0, mem_en} !== {exp1, ~exp1, 1'b1}) begin
        errors++;
        $display("FAIL burst_seq[%0d] (reset=%0d): gnt1=%b gnt0=%b en=%b, required %b %b 1",
                 i, do_reset, gnt1, gnt0, mem_en, exp1, ~exp1);
      end
    end
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
  endtask

  task automatic test_interleaved;
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'd1;
    #1;
    checks++;
    if ({gnt0, gnt1, mem_addr} !== {2'b10, 8'd1}) begin
      errors++;
      $display("FAIL il_grant0: gnt0=%b gnt1=%b addr=%0d, required 1 0 1", gnt0, gnt1, mem_addr);
    end
    exp_q.push_back('{1'b0, 8'h11});
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 8'd2;
    #1;
    checks++;
    if ({gnt0, gnt1, mem_addr} !== {2'b01, 8'd2}) begin
      errors++;
      $display("FAIL il_grant1: gnt0=%b gnt1=%b addr=%0d, required 0 1 2", gnt0, gnt1, mem_addr);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL il_sb0: scoreboard empty, required one entry");
    end else begin
      e = exp_q.pop_front();
      if ({rvalid0, rdata0, rvalid1} !== {1'b1, e.data, 1'b0}) begin
        errors++;
        $display("FAIL il_return0: rvalid0=%b rdata0=%h rvalid1=%b, required 1 %h 0", rvalid0, rdata0, rvalid1, e.data);
      end
    end
    exp_q.push_back('{1'b1, 8'h22});
    @(negedge clk);
    req1 = 1'b0;
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL il_sb1: scoreboard empty, required one entry");
    end else begin
      e = exp_q.pop_front();
      if ({rvalid1, rdata1, rvalid0} !== {1'b1, e.data, 1'b0}) begin
        errors++;
        $display("FAIL il_return1: rvalid1=%b rdata1=%h rvalid0=%b, required 1 %h 0", rvalid1, rdata1, rvalid0, e.data);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if ({rvalid0, rvalid1} !== 2'b00) begin
      errors++;
      $display("FAIL il_quiet: rvalid0=%b rvalid1=%b, required 0 0", rvalid0, rvalid1);
    end
  endtask

  task automatic test_idle_cnt;
    bit exp1;
    we0 = 1'b1; we1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req0 = 1'b1;
      #1;
      checks++;
      if ({gnt0, gnt1} !== 2'b10) begin
        errors++;
        $display("FAIL idle_pre[%0d]: gnt0=%b gnt1=%b, required 1 0", i, gnt0, gnt1);
      end
    end
    @(negedge clk);
    req0 = 1'b0;
    #1;
    checks++;
    if ({gnt0, gnt1, mem_en} !== 3'b000) begin
      errors++;
      $display("FAIL idle_gap: gnt0=%b gnt1=%b en=%b, required 0 0 0", gnt0, gnt1, mem_en);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req0 = 1'b1; req1 = 1'b1;
      #1;
      exp1 = (i == 4);
      checks++;
      if ({gnt1, gnt0} !== {exp1, ~exp1}) begin
        errors++;
        $display("FAIL idle_post[%0d]: gnt1=%b gnt0=%b, required %b %b", i, gnt1, gnt0, exp1, ~exp1);
      end
    end
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
  endtask

  task automatic test_reset_mid_read;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      req1 = 1'b1; we1 = 1'b1; addr1 = 8'd50;
    end
    @(negedge clk);
    req1 = 1'b0; req0 = 1'b1; we0 = 1'b0; addr0 = 8'd1;
    #1;
    checks++;
    if ({gnt0, gnt1, mem_we} !== 3'b100) begin
      errors++;
      $display("FAIL midrst_grant: gnt0=%b gnt1=%b we=%b, required 1 0 0", gnt0, gnt1, mem_we);
    end
    #2;
    rst = 1'b0; req0 = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({rvalid0, rvalid1, rdata0} !== 10'b0) begin
      errors++;
      $display("FAIL midrst_no_rvalid: rvalid0=%b rvalid1=%b rdata0=%h, required 0 0 00", rvalid0, rvalid1, rdata0);
    end
    test_burst(1'b0);
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_port1_read();
    test_burst(1'b1);
    test_interleaved();
    test_idle_cnt();
    test_reset_mid_read();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
